axis_spi_reg_bridge: RTL and testbench

//  Register-access front end for the AXIS SPI master. Turns one read/write request into a

---
 rtl/axis_spi_reg_bridge.sv | 169 ++++++++++++++++
 tb/tb_axis_spi_reg_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_spi_reg_bridge.sv
// Register-access bridge: frames one read/write request into an AXIS byte stream for the SPI master
// and folds the returned MISO bytes into a single response (read data + error flag).
module axis_spi_reg_bridge #(
    parameter int ADDR_BYTES     = 1,
    parameter int DATA_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_rw_i,
    input  logic [ADDR_BYTES*8-2:0] req_addr_i,
    input  logic [DATA_BYTES*8-1:0] req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_BYTES*8-1:0] rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [7:0]              m_tdata_o,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic                    m_tlast_o,
    input  logic [7:0]              s_tdata_i,
    input  logic                    s_tvalid_i,
    output logic                    s_tready_o,
    input  logic                    s_tlast_i
);

    localparam int N  = ADDR_BYTES + DATA_BYTES;
    localparam int DW = DATA_BYTES * 8;
    localparam int FW = N * 8;
    localparam int CW = $clog2(N + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // Handshakes: a byte/request/response transfers on a rising clk_i edge where valid and
    // ready are both high; a source holds its payload stable while valid && !ready.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [FW-1:0]   tx_q;
    logic [DW-1:0]   rdata_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [TW-1:0]   tmo_q;
    logic            err_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            m_tvalid_q;
    logic            m_tlast_q;
    logic            s_tready_q;

    logic            tx_hs_d;
    logic            rx_hs_d;
    logic            rx_final_d;
    logic            tmo_hit_d;
    logic [FW-1:0]   tx_load_d;
    logic [DW-1:0]   rdata_shift_d;

    assign tx_hs_d       = m_tvalid_q && m_tready_i;
    assign rx_hs_d       = s_tvalid_i && s_tready_q;
    assign rx_final_d    = (rx_cnt_q == CW'(N - 1));
    assign tmo_hit_d     = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    // Reads send filler zeros in the data phase so the slave can drive MISO.
    assign tx_load_d     = {req_rw_i, req_addr_i, (req_rw_i ? {DW{1'b0}} : req_wdata_i)};
    assign rdata_shift_d = (rdata_q << 8) | DW'(s_tdata_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            tx_q        <= '0;
            rdata_q     <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            s_tready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        tx_q        <= tx_load_d;
                        rdata_q     <= '0;
                        tx_cnt_q    <= '0;
                        rx_cnt_q    <= '0;
                        tmo_q       <= '0;
                        err_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        m_tvalid_q  <= 1'b1;
                        m_tlast_q   <= (N == 1);
                        s_tready_q  <= 1'b1;
                        state_q     <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (tx_hs_d) begin
                        tx_q     <= tx_q << 8;
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                        if (tx_cnt_q == CW'(N - 1)) begin
                            m_tvalid_q <= 1'b0;
                            m_tlast_q  <= 1'b0;
                        end else begin
                            m_tlast_q <= (tx_cnt_q == CW'(N - 2));
                        end
                    end

                    // An rx handshake restarts the idle counter and beats a same-cycle timeout.
                    if (rx_hs_d) begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                        tmo_q    <= '0;
                        if (rx_cnt_q >= CW'(ADDR_BYTES)) begin
                            rdata_q <= rdata_shift_d;
                        end
                        if (s_tlast_i || rx_final_d) begin
                            err_q       <= !(s_tlast_i && rx_final_d);
                            rsp_valid_q <= 1'b1;
                            s_tready_q  <= 1'b0;
                            m_tvalid_q  <= 1'b0;
                            m_tlast_q   <= 1'b0;
                            tx_q        <= '0;
                            state_q     <= ST_RESP;
                        end
                    end else if (tmo_hit_d) begin
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        s_tready_q  <= 1'b0;
                        m_tvalid_q  <= 1'b0;
                        m_tlast_q   <= 1'b0;
                        tx_q        <= '0;
                        state_q     <= ST_RESP;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end

                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign m_tdata_o   = tx_q[FW-1 -: 8];
    assign m_tvalid_o  = m_tvalid_q;
    assign m_tlast_o   = m_tlast_q;
    assign s_tready_o  = s_tready_q;

endmodule

// File: tb/tb_axis_spi_reg_bridge.sv
// Bench for axis_spi_reg_bridge: table of full register accesses plus directed corner sequences
// (tx stall, response stall, early end, missing tlast, timeout, disabled timeout, mid-frame reset).
module tb_axis_spi_reg_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid = 1'b0, req_ready, req_rw = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [15:0] rsp_rdata;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready = 1'b0, m_tlast;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;

    logic        req_valid0 = 1'b0, req_ready0, req_rw0 = 1'b0;
    logic [6:0]  req_addr0 = '0;
    logic [15:0] req_wdata0 = '0;
    logic        rsp_valid0, rsp_ready0 = 1'b0, rsp_err0;
    logic [15:0] rsp_rdata0;
    logic [7:0]  m_tdata0;
    logic        m_tvalid0, m_tready0 = 1'b1, m_tlast0;
    logic [7:0]  s_tdata0 = '0;
    logic        s_tvalid0 = 1'b0, s_tready0, s_tlast0 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic        rw;
        logic [6:0]  addr;
        logic [15:0] wdata;
        logic [23:0] miso;
        logic [23:0] tx;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    axis_spi_reg_bridge #(.ADDR_BYTES(1), .DATA_BYTES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tlast_o(m_tlast),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tlast_i(s_tlast)
    );

    axis_spi_reg_bridge #(.ADDR_BYTES(1), .DATA_BYTES(2), .TIMEOUT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_rw_i(req_rw0),
        .req_addr_i(req_addr0), .req_wdata_i(req_wdata0),
        .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0),
        .m_tdata_o(m_tdata0), .m_tvalid_o(m_tvalid0), .m_tready_i(m_tready0), .m_tlast_o(m_tlast0),
        .s_tdata_i(s_tdata0), .s_tvalid_i(s_tvalid0), .s_tready_o(s_tready0), .s_tlast_i(s_tlast0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_req(input logic rw, input logic [6:0] addr, input logic [15:0] wdata);
        int w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = '0;
        check("tvalid_after_req", {31'd0, m_tvalid}, 32'd1);
        check("s_tready_xfer", {31'd0, s_tready}, 32'd1);
    endtask

    task automatic take_tx(input logic exp_last, input int stall);
        int w = 0;
        logic [7:0] exp_d;
        while (!m_tvalid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!m_tvalid) begin
            check("tx_wait", 32'd0, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("tx_unexpected", 32'd1, 32'd0);
            return;
        end
        exp_d = exp_q.pop_front();
        check("tx_data", {24'd0, m_tdata}, {24'd0, exp_d});
        check("tx_last", {31'd0, m_tlast}, {31'd0, exp_last});
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_tvalid", {31'd0, m_tvalid}, 32'd1);
            check("stall_tdata", {24'd0, m_tdata}, {24'd0, exp_d});
            check("stall_tlast", {31'd0, m_tlast}, {31'd0, exp_last});
        end
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
    endtask

    task automatic give_rx(input logic [7:0] d, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
    endtask

    task automatic take_rsp(input logic [15:0] exp_rdata, input logic exp_err, input int hold);
        int w = 0;
        while (!rsp_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        check("req_ready_resp", {31'd0, req_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
            check("hold_rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
        check("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [23:0] tx   = v.tx;
        logic [23:0] miso = v.miso;
        for (int b = 0; b < 3; b++) exp_q.push_back(tx[23-8*b -: 8]);
        send_req(v.rw, v.addr, v.wdata);
        for (int b = 0; b < 3; b++) begin
            take_tx(b == 2, 0);
            give_rx(miso[23-8*b -: 8], b == 2);
        end
        take_rsp(v.rdata, 1'b0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench stalled");
    end

    initial begin
        int cyc;
        logic seen;

        //            rw    addr   wdata     miso        tx          rdata
        vecs[0] = '{1'b0, 7'h15, 16'hBEEF, 24'h112233, 24'h15BEEF, 16'h2233};
        vecs[1] = '{1'b1, 7'h2A, 16'h0000, 24'h001234, 24'hAA0000, 16'h1234};
        vecs[2] = '{1'b0, 7'h7F, 16'h0001, 24'hFFA55A, 24'h7F0001, 16'hA55A};
        vecs[3] = '{1'b1, 7'h00, 16'hFFFF, 24'h5E00FF, 24'h800000, 16'h00FF};

        // reset state
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_m_tdata", {24'd0, m_tdata}, 32'd0);
        check("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        check("rst_s_tready", {31'd0, s_tready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // tx back-pressure on byte 1, then response held for 10 cycles
        exp_q.push_back(8'h33); exp_q.push_back(8'hC0); exp_q.push_back(8'hDE);
        send_req(1'b0, 7'h33, 16'hC0DE);
        take_tx(1'b0, 0); give_rx(8'h01, 1'b0);
        take_tx(1'b0, 5); give_rx(8'h02, 1'b0);
        take_tx(1'b1, 0); give_rx(8'h03, 1'b1);
        take_rsp(16'h0203, 1'b0, 10);

        // early tlast on rx byte 1 while tx byte 2 still pending
        exp_q.push_back(8'h85); exp_q.push_back(8'h00);
        send_req(1'b1, 7'h05, 16'hFFFF);
        take_tx(1'b0, 0); give_rx(8'hAB, 1'b0);
        take_tx(1'b0, 0);
        check("pending_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("pending_tlast", {31'd0, m_tlast}, 32'd1);
        give_rx(8'hCD, 1'b1);
        check("early_tvalid_drop", {31'd0, m_tvalid}, 32'd0);
        check("early_s_tready_drop", {31'd0, s_tready}, 32'd0);
        take_rsp(16'h00CD, 1'b1, 0);

        // final rx byte without tlast
        exp_q.push_back(8'h81); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_req(1'b1, 7'h01, 16'h0000);
        take_tx(1'b0, 0); give_rx(8'h10, 1'b0);
        take_tx(1'b0, 0); give_rx(8'h20, 1'b0);
        take_tx(1'b1, 0); give_rx(8'h30, 1'b0);
        take_rsp(16'h2030, 1'b1, 0);

        // timeout: no tx acceptance, no rx bytes; cycle 1 is the one after the request edge
        send_req(1'b0, 7'h44, 16'h1234);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycle", cyc, 32'd17);
        check("timeout_tvalid", {31'd0, m_tvalid}, 32'd0);
        take_rsp(16'h0000, 1'b1, 0);

        // disabled timeout waits indefinitely, then completes normally
        @(negedge clk);
        check("t0_req_ready", {31'd0, req_ready0}, 32'd1);
        req_valid0 = 1'b1; req_rw0 = 1'b0; req_addr0 = 7'h01; req_wdata0 = 16'h0203;
        @(negedge clk);
        req_valid0 = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (rsp_valid0) seen = 1'b1;
        end
        check("t0_no_timeout", {31'd0, seen}, 32'd0);
        check("t0_tx_done", {31'd0, m_tvalid0}, 32'd0);
        check("t0_s_tready", {31'd0, s_tready0}, 32'd1);
        for (int b = 0; b < 3; b++) begin
            s_tvalid0 = 1'b1; s_tdata0 = 8'h0A + 8'(b); s_tlast0 = (b == 2);
            @(negedge clk);
        end
        s_tvalid0 = 1'b0; s_tlast0 = 1'b0;
        check("t0_rsp_valid", {31'd0, rsp_valid0}, 32'd1);
        check("t0_rsp_err", {31'd0, rsp_err0}, 32'd0);
        check("t0_rsp_rdata", {16'd0, rsp_rdata0}, 32'h0B0C);
        rsp_ready0 = 1'b1;
        @(negedge clk);
        rsp_ready0 = 1'b0;
        check("t0_rsp_cleared", {31'd0, rsp_valid0}, 32'd0);

        // reset mid-frame, then a clean frame from byte 0
        exp_q.push_back(8'h66);
        send_req(1'b0, 7'h66, 16'h7788);
        take_tx(1'b0, 0); give_rx(8'h99, 1'b0);
        check("mid_tvalid", {31'd0, m_tvalid}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("async_m_tdata", {24'd0, m_tdata}, 32'd0);
        check("async_s_tready", {31'd0, s_tready}, 32'd0);
        check("async_req_ready", {31'd0, req_ready}, 32'd0);
        check("async_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec('{1'b0, 7'h12, 16'h3456, 24'hAABBCC, 24'h123456, 16'hBBCC});
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
